// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - state encoding and shared defaults for the pipeline-register stages
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } pipe_state_e;

  localparam int unsigned PIPE_INST_W   = 19;
  localparam int unsigned PIPE_PC_W     = 12;
  localparam logic [31:0] PIPE_NOP_INST = 32'd0;

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - one instruction+PC holding register with load and synchronous clear
module pipe_skid_entry #(
  parameter int unsigned  W       = 31,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // Clear wins over load so a squash can never be undone by a same-cycle write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= CLR_VAL;
    end else if (clear_i) begin
      data_q <= CLR_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - elastic IF/ID register with two-entry skid buffer; IF_ID_STAGE_STATS_EN adds stall/flush counters
module if_id_stage
  import pipe_pkg::*;
#(
  parameter int unsigned       INST_W   = PIPE_INST_W,
  parameter int unsigned       PC_W     = PIPE_PC_W,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(PIPE_NOP_INST)
) (
  input  logic              clk,
  input  logic              resetbar,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc
`ifdef IF_ID_STAGE_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int unsigned  W       = INST_W + PC_W;
  localparam logic [W-1:0] CLR_VAL = {NOP_INST, {PC_W{1'b0}}};

  pipe_state_e  state_q, state_d;
  logic         in_ready_q, out_valid_q;
  logic         in_fire, out_fire;
  logic         main_load, main_clear, skid_load, skid_clear;
  logic [W-1:0] in_word, main_d, main_q, skid_q;

  assign in_word  = {in_inst, in_pc};
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d     = in_word;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain path can move.
          if (out_fire) begin
            main_load  = 1'b1;
            main_d     = skid_q;
            skid_clear = 1'b1;
            state_d    = ONE;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Handshake outputs are registered from the next state to keep decode's ready off the fetch path.
  always_ff @(posedge clk or negedge resetbar) begin
    if (!resetbar) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  pipe_skid_entry #(
    .W       (W),
    .CLR_VAL (CLR_VAL)
  ) u_main (
    .clk_i   (clk),
    .rst_ni  (resetbar),
    .load_i  (main_load),
    .clear_i (main_clear),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  pipe_skid_entry #(
    .W       (W),
    .CLR_VAL (CLR_VAL)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (resetbar),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .d_i     (in_word),
    .q_o     (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_inst  = main_q[W-1:PC_W];
  assign out_pc    = main_q[PC_W-1:0];

`ifdef IF_ID_STAGE_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge resetbar) begin
    if (!resetbar) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage (IF_ID_STAGE_STATS_EN enables counter checks)
module tb_if_id_stage;

  localparam int INST_W = 19;
  localparam int PC_W   = 12;
  localparam int W      = INST_W + PC_W;

  logic              clk = 1'b0;
  logic              resetbar = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [INST_W-1:0] in_inst = '0;
  logic [PC_W-1:0]   in_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
`ifdef IF_ID_STAGE_STATS_EN
  logic [15:0]       stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_low  = 0;
  bit stream_mon = 1'b0;

  logic [W-1:0] mq[$];
  bit           m_rdy = 1'b1;
  logic [15:0]  m_stall = '0, m_flush = '0;
  bit           m_fi, m_fo;

  logic [W-1:0] log_w[$];
  int           log_c[$];

  if_id_stage dut (
    .clk       (clk),
    .resetbar  (resetbar),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc)
`ifdef IF_ID_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two entries; ready whenever it has room after the edge.
  always @(posedge clk or negedge resetbar) begin
    if (!resetbar) begin
      mq.delete();
      m_rdy   = 1'b1;
      m_stall = '0;
      m_flush = '0;
    end else begin
      cyc++;
      m_fi = in_valid && m_rdy;
      m_fo = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready && (m_stall != 16'hFFFF)) m_stall++;
      if (flush && (m_flush != 16'hFFFF)) m_flush++;
      if (flush) mq.delete();
      else begin
        if (m_fo) void'(mq.pop_front());
        if (m_fi) mq.push_back({in_inst, in_pc});
      end
      m_rdy = (mq.size() < 2);
    end
  end

  always @(negedge clk) begin
    logic         ev;
    logic [W-1:0] ew;
    ev = (mq.size() > 0);
    ew = ev ? mq[0] : {INST_W'(0), PC_W'(0)};
    chk("out_valid", out_valid, ev);
    chk("out_inst", out_inst, ew[W-1:PC_W]);
    chk("out_pc", out_pc, ew[PC_W-1:0]);
    chk("in_ready", in_ready, m_rdy);
`ifdef IF_ID_STAGE_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`endif
    if (stream_mon && !in_ready) rdy_low++;
    if (out_valid && out_ready) begin
      log_w.push_back({out_inst, out_pc});
      log_c.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [INST_W-1:0] inst, input logic [PC_W-1:0] pc);
    bit rdy;
    int n;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    n = 0;
    do begin
      rdy = in_ready;
      step();
      n++;
    end while (!rdy && n < 64);
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: pc %0d never accepted", pc);
    end
    in_valid = 1'b0;
    in_inst  = INST_W'($urandom);
    in_pc    = PC_W'($urandom);
  endtask

  task automatic reset_pulse();
    resetbar = 1'b0;
    step();
    step();
    resetbar = 1'b1;
  endtask

  initial begin
    int base;
    int found;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int found;
    #1;
    resetbar = 1'b0;
    step();
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_inst", out_inst, 19'd0);
    chk("rst_out_pc", out_pc, 12'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    resetbar = 1'b1;
    step();

    // Single transfer
    out_ready = 1'b1;
    push(19'd110, 12'd72);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_inst", out_inst, 19'd110);
    chk("t1_pc", out_pc, 12'd72);
    chk("t1_ready", in_ready, 1'b1);
    step();
    chk("t1_drain_valid", out_valid, 1'b0);
    chk("t1_drain_inst", out_inst, 19'd0);

    // Stall fill
    out_ready = 1'b0;
    base = log_w.size();
    push(19'd110, 12'd72);
    push(19'd12400, 12'd76);
    fork
      push(19'd555, 12'd80);
      begin
        repeat (3) step();
        chk("sf_hold_inst", out_inst, 19'd110);
        chk("sf_hold_pc", out_pc, 12'd72);
        chk("sf_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    chk("sf_count", log_w.size() - base, 3);
    if (log_w.size() - base == 3) begin
      chk("sf_e0", log_w[base],   {19'd110, 12'd72});
      chk("sf_e1", log_w[base+1], {19'd12400, 12'd76});
      chk("sf_e2", log_w[base+2], {19'd555, 12'd80});
      chk("sf_gap1", log_c[base+1] - log_c[base], 1);
      chk("sf_gap2", log_c[base+2] - log_c[base+1], 1);
    end

    // Streaming
    base = log_w.size();
    rdy_low = 0;
    stream_mon = 1'b1;
    for (int i = 0; i < 8; i++) push(INST_W'(1000 + i), PC_W'(4 * i));
    repeat (3) step();
    stream_mon = 1'b0;
    chk("st_rdy_low", rdy_low, 0);
    chk("st_count", log_w.size() - base, 8);
    if (log_w.size() - base == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("st_entry", log_w[base+i], {INST_W'(1000 + i), PC_W'(4 * i)});
        if (i > 0) chk("st_gap", log_c[base+i] - log_c[base+i-1], 1);
      end
    end

    // Flush with full buffer
    out_ready = 1'b0;
    push(19'd110, 12'd72);
    push(19'd12400, 12'd76);
    chk("fl_pre_ready", in_ready, 1'b0);
    base = log_w.size();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 19'd999;
    in_pc    = 12'd84;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_inst", out_inst, 19'd0);
    chk("fl_pc", out_pc, 12'd0);
    chk("fl_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("fl_no_output", log_w.size() - base, 0);
    found = 0;
    foreach (log_w[i]) if (log_w[i][W-1:PC_W] == 19'd999) found++;
    chk("fl_999_seen", found, 0);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    push(19'd12400, 12'd76);
    chk("ar_pre_valid", out_valid, 1'b1);
    @(posedge clk);
    #3;
    resetbar = 1'b0;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_pc", out_pc, 12'd0);
    chk("ar_ready", in_ready, 1'b1);
    step();
    resetbar  = 1'b1;
    out_ready = 1'b1;
    push(19'd1, 12'd4);
    chk("ar_post_valid", out_valid, 1'b1);
    chk("ar_post_inst", out_inst, 19'd1);
    chk("ar_post_pc", out_pc, 12'd4);
    step();

`ifdef IF_ID_STAGE_STATS_EN
    reset_pulse();
    out_ready = 1'b0;
    push(19'd7, 12'd8);
    repeat (5) step();
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    chk("stats_stall", stall_cnt, 16'd5);
    chk("stats_flush", flush_cnt, 16'd2);
`else
    reset_pulse();
`endif
    chk("end_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
